// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and execute training bus of the branch predictor (BP_STATS_EN adds counters)
interface branch_predictor_if #(
   parameter int PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] PCF_i;
   logic                PredTakenF_o;
   logic [PC_WIDTH-1:0] PredTargetF_o;
   logic                UpdateEn_i;
   logic [PC_WIDTH-1:0] PCE_i;
   logic                IsJumpE_i;
   logic                TakenE_i;
   logic [PC_WIDTH-1:0] TargetE_i;
   logic                PredTakenE_i;
   logic [PC_WIDTH-1:0] PredTargetE_i;
   logic                MispredictE_o;
   logic [PC_WIDTH-1:0] RedirectPCE_o;
`ifdef BP_STATS_EN
   logic [31:0]         BranchCountE_o;
   logic [31:0]         MispredCountE_o;
`endif

   // Pipeline side: drives fetch PC and execute-stage resolution.
   modport master (
      output PCF_i, UpdateEn_i, PCE_i, IsJumpE_i, TakenE_i, TargetE_i,
             PredTakenE_i, PredTargetE_i,
      input  PredTakenF_o, PredTargetF_o, MispredictE_o, RedirectPCE_o
`ifdef BP_STATS_EN
      , input BranchCountE_o, MispredCountE_o
`endif
   );

   // Predictor side.
   modport slave (
      input  PCF_i, UpdateEn_i, PCE_i, IsJumpE_i, TakenE_i, TargetE_i,
             PredTakenE_i, PredTargetE_i,
      output PredTakenF_o, PredTargetF_o, MispredictE_o, RedirectPCE_o
`ifdef BP_STATS_EN
      , output BranchCountE_o, MispredCountE_o
`endif
   );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; optional BP_STATS_EN statistics counters
module branch_predictor #(
   parameter int PC_WIDTH   = 32,
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8   // INDEX_BITS + TAG_BITS + 2 must not exceed PC_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   branch_predictor_if.slave   bus
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   logic                valid_q  [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [PC_WIDTH-1:0] target_q [ENTRIES];

   logic [INDEX_BITS-1:0] f_idx, e_idx;
   logic [TAG_BITS-1:0]   f_tag, e_tag;
   logic                  f_hit, e_hit;
   logic                  pred_taken;

   logic       wr_ctr, wr_alloc, wr_target;
   logic [1:0] ctr_new;

   // PC[1:0] never take part in addressing.
   assign f_idx = bus.PCF_i[INDEX_BITS+1:2];
   assign f_tag = bus.PCF_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign e_idx = bus.PCE_i[INDEX_BITS+1:2];
   assign e_tag = bus.PCE_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

   // Fetch lookup; valid bits clear asynchronously so reset forces a miss.
   assign f_hit             = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken        = f_hit && ctr_q[f_idx][1];
   assign bus.PredTakenF_o  = pred_taken;
   assign bus.PredTargetF_o = pred_taken ? target_q[f_idx] : bus.PCF_i + PC_STEP;

   // Execute-stage misprediction detection and redirect target.
   assign bus.MispredictE_o = bus.UpdateEn_i &&
                              ((bus.PredTakenE_i != bus.TakenE_i) ||
                               (bus.TakenE_i && (bus.PredTargetE_i != bus.TargetE_i)));
   assign bus.RedirectPCE_o = bus.TakenE_i ? bus.TargetE_i : bus.PCE_i + PC_STEP;

   assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

   // Training decision: which fields of the indexed entry change and the new counter.
   always_comb begin
      wr_ctr    = 1'b0;
      wr_alloc  = 1'b0;
      wr_target = 1'b0;
      ctr_new   = ctr_q[e_idx];
      if (bus.UpdateEn_i) begin
         if (e_hit) begin
            wr_ctr = 1'b1;
            if (bus.IsJumpE_i) begin
               ctr_new   = 2'b11;
               wr_target = 1'b1;
            end else if (bus.TakenE_i) begin
               ctr_new   = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
               wr_target = 1'b1;
            end else begin
               ctr_new   = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
            end
         end else if (bus.TakenE_i) begin
            wr_ctr    = 1'b1;
            wr_alloc  = 1'b1;
            wr_target = 1'b1;
            ctr_new   = bus.IsJumpE_i ? 2'b11 : 2'b10;
         end
      end
   end

   // Valid bits and counters: cleared to invalid / weakly not-taken on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else begin
         if (wr_ctr)   ctr_q[e_idx]   <= ctr_new;
         if (wr_alloc) valid_q[e_idx] <= 1'b1;
      end
   end

   // Tag and target payload; meaningless while the valid bit is clear, so unreset.
   always_ff @(posedge clk_i) begin
      if (wr_target) target_q[e_idx] <= bus.TargetE_i;
      if (wr_alloc)  tag_q[e_idx]    <= e_tag;
   end

`ifdef BP_STATS_EN
   logic [31:0] branch_cnt_q, mispred_cnt_q;

   // Saturating counts of resolved branches and of mispredictions.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         if (bus.UpdateEn_i && (branch_cnt_q != 32'hFFFF_FFFF))
            branch_cnt_q <= branch_cnt_q + 32'd1;
         if (bus.MispredictE_o && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign bus.BranchCountE_o  = branch_cnt_q;
   assign bus.MispredCountE_o = mispred_cnt_q;
`endif
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit for the five-stage pipelined RV32I core. It sits beside the fetch-stage PC register and instruction memory, and supplies a predicted next PC in the same cycle as the fetch. It combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. The unit is trained from the execute stage and flags mispredictions so that top-level logic can flush the decode and execute registers and redirect the PC.

## Interface
Parameters:
- PC_WIDTH, 32, width of all PC and target values
- INDEX_BITS, 6, log2 of the number of BTB entries (64)
- TAG_BITS, 8, stored tag width; INDEX_BITS+TAG_BITS+2 <= PC_WIDTH is required

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- PCF_i  in  PC_WIDTH  fetch-stage PC to look up
- PredTakenF_o  out  1  prediction for PCF_i is "taken"
- PredTargetF_o  out  PC_WIDTH  predicted next PC
- UpdateEn_i  in  1  execute stage holds a valid branch or jump this cycle
- PCE_i  in  PC_WIDTH  PC of the resolving instruction
- IsJumpE_i  in  1  resolving instruction is JAL/JALR
- TakenE_i  in  1  actual outcome
- TargetE_i  in  PC_WIDTH  actual target (PCTargetE)
- PredTakenE_i  in  1  PredTakenF_o value carried down the pipeline for this instruction
- PredTargetE_i  in  PC_WIDTH  PredTargetF_o value carried down the pipeline
- MispredictE_o  out  1  flush request
- RedirectPCE_o  out  PC_WIDTH  correct next PC when MispredictE_o=1

## Operation
Addressing:
- index = PC[INDEX_BITS+1:2]
- tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
- PC[1:0] are ignored

Each entry holds: valid, tag, target (PC_WIDTH bits), ctr (2 bits).

Lookup (combinational on PCF_i):
- hit = valid & (tag match)
- PredTakenF_o = hit & ctr[1]
- PredTargetF_o = PredTakenF_o ? target : PCF_i+4 (the +4 wraps modulo 2^PC_WIDTH)

Update (on clock edge, when UpdateEn_i=1):
- Hit, and IsJumpE_i=1: ctr is set to 11 and target is overwritten with TargetE_i.
- Hit, and IsJumpE_i=0:
  - TakenE_i=1: ctr increments, saturating at 11, and target is overwritten.
  - TakenE_i=0: ctr decrements, saturating at 00, and target is kept.
- Miss, and TakenE_i=1: the entry is allocated or replaced: valid=1, new tag, target=TargetE_i, ctr=11 if IsJumpE_i else 10.
- Miss, and TakenE_i=0: no write.

Mispredict (combinational):
- MispredictE_o = UpdateEn_i & ((PredTakenE_i != TakenE_i) | (TakenE_i & PredTargetE_i != TargetE_i))
- RedirectPCE_o = TakenE_i ? TargetE_i : PCE_i+4
- RedirectPCE_o is driven even when MispredictE_o=0.

Reset:
- All valid bits clear and all ctr fields are set to 01, asynchronously.
- Target and tag contents are don't-care.
- While rst_ni=0: PredTakenF_o=0, PredTargetF_o=PCF_i+4, and MispredictE_o follows its equation with every lookup missing.

## Timing
- Lookup has zero-cycle latency and matches the combinational instruction memory read.
- An update becomes visible to lookups from the cycle after the edge on which it is written.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-edge contents. There is no write-to-read bypass.
- Misprediction costs 2 cycles; the flush is performed by top-level logic.
- Reset asserted mid-operation clears the table immediately. Any update pending in that cycle is lost.
- Deasserting reset takes effect on the next rising edge.

## Configuration
BP_STATS_EN:
- Defined: adds outputs BranchCountE_o[31:0] and MispredCountE_o[31:0].
  - BranchCountE_o increments on each edge with UpdateEn_i=1.
  - MispredCountE_o increments on each edge with MispredictE_o=1.
  - Both saturate at 0xFFFFFFFF and reset asynchronously to 0.
- Undefined: the ports and counters do not exist, and prediction behaviour is identical.

## Test plan
1. Reset, then PCF_i=0x100: PredTakenF_o=0 and PredTargetF_o=0x104.
2. Update PCE_i=0x100, TakenE_i=1, TargetE_i=0x80, PredTakenE_i=0:
   - In the same cycle, MispredictE_o=1 and RedirectPCE_o=0x80.
   - Next cycle, PCF_i=0x100 gives PredTakenF_o=1 and PredTargetF_o=0x80.
3. Hysteresis: after test 2 (ctr=10), apply one not-taken update and then look up 0x100: not taken (ctr=01). Then apply two taken updates: taken (ctr=11). Then one not-taken update: still taken (ctr=10).
4. Aliasing with INDEX_BITS=6:
   - With 0x100 allocated, look up 0x200 (same index, different tag): PredTakenF_o=0, PredTargetF_o=0x204.
   - A taken update at 0x200 with target 0x300 replaces the entry. A later lookup of 0x100 misses.
5. Jump and wrap-around: update IsJumpE_i=1, PCE_i=0x40, TargetE_i=0x10. Then lookup 0x40 gives taken, 0x10. Lookup 0xFFFFFFFC on a miss gives PredTargetF_o=0x0.
6. Same-cycle conflict and reset: update 0x100 as taken while PCF_i=0x100 on a cold table.
   - In that cycle, prediction is not taken; in the next cycle it is taken.
   - Pulse rst_ni low mid-cycle: the lookup immediately misses.
   - With BP_STATS_EN defined, both counters read 0.
